// File: rtl/task_seq_pkg.sv
// Shared opcodes, FSM states and ROM word field layout for the task sequencer.
// Field offsets are functions of PC_W/TASKS_W so every user derives the same word layout.
package task_seq_pkg;

   localparam int COND_W = 4;

   localparam logic [2:0] OP_NEXT = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BRC  = 3'd2;
   localparam logic [2:0] OP_WAIT = 3'd3;
   localparam logic [2:0] OP_LDC  = 3'd4;
   localparam logic [2:0] OP_LOOP = 3'd5;
   localparam logic [2:0] OP_CALL = 3'd6;
   localparam logic [2:0] OP_RET  = 3'd7;

   localparam logic [1:0] CSEL_END = 2'b11;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   function automatic int prog_w(int pc_w, int tasks_w);
      return 3 + 2 + pc_w + tasks_w;
   endfunction

   function automatic int arg_lsb(int tasks_w);
      return tasks_w;
   endfunction

   function automatic int csel_lsb(int pc_w, int tasks_w);
      return tasks_w + pc_w;
   endfunction

   function automatic int op_lsb(int pc_w, int tasks_w);
      return tasks_w + pc_w + 2;
   endfunction

endpackage

// File: rtl/task_seq_ctrl_if.sv
// Sequencer bus: start/done handshake, ROM fetch port, conditions and task outputs.
// slave is the sequencer side; master is the controller/ROM/datapath side.
interface task_seq_ctrl_if #(
   parameter int PC_W    = 4,
   parameter int TASKS_W = 16
);
   import task_seq_pkg::*;

   logic                              start;
   logic [PC_W-1:0]                   start_addr;
   logic                              busy;
   logic                              done;
   logic [PC_W-1:0]                   prog_addr;
   logic [prog_w(PC_W, TASKS_W)-1:0]  prog_data;
   logic [COND_W-1:0]                 cond;
   logic [TASKS_W-1:0]                tasks;
   logic [PC_W-1:0]                   pc;

   modport slave (
      input  start, start_addr, prog_data, cond,
      output busy, done, prog_addr, tasks, pc
   );

   modport master (
      output start, start_addr, prog_data, cond,
      input  busy, done, prog_addr, tasks, pc
   );

endinterface

// File: rtl/task_seq_nextpc.sv
// Combinational word decode: next pc, loop counter and return address for the executing word.
// Zero latency; no flow control (WAIT stalls by holding pc). TASK_SEQ_CALL_EN adds CALL/RET.
module task_seq_nextpc
   import task_seq_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int TASKS_W = 16
) (
   input  logic [prog_w(PC_W, TASKS_W)-1:0] word,
   input  logic [COND_W-1:0]                cond,
   input  logic [PC_W-1:0]                  pc,
   input  logic [PC_W-1:0]                  lcnt,
`ifdef TASK_SEQ_CALL_EN
   input  logic [PC_W-1:0]                  ret,
   output logic [PC_W-1:0]                  ret_nxt,
`endif
   output logic [PC_W-1:0]                  pc_nxt,
   output logic [PC_W-1:0]                  lcnt_nxt,
   output logic                             is_end,
   output logic [TASKS_W-1:0]               word_tasks
);
   localparam int ARG_L  = arg_lsb(TASKS_W);
   localparam int CSEL_L = csel_lsb(PC_W, TASKS_W);
   localparam int OP_L   = op_lsb(PC_W, TASKS_W);

   logic [2:0]      op;
   logic [1:0]      csel;
   logic [PC_W-1:0] arg;
   logic [PC_W-1:0] pc_inc;
   logic            c;

   assign op         = word[OP_L +: 3];
   assign csel       = word[CSEL_L +: 2];
   assign arg        = word[ARG_L +: PC_W];
   assign word_tasks = word[TASKS_W-1:0];
   assign c          = cond[csel];
   assign pc_inc     = pc + PC_W'(1);
   assign is_end     = (op == OP_NEXT) && (csel == CSEL_END);

   always_comb begin
      pc_nxt   = pc_inc;
      lcnt_nxt = lcnt;
`ifdef TASK_SEQ_CALL_EN
      ret_nxt  = ret;
`endif
      case (op)
         OP_NEXT: if (is_end) pc_nxt = pc;
         OP_JMP:  pc_nxt = arg;
         OP_BRC:  pc_nxt = c ? arg : pc_inc;
         OP_WAIT: pc_nxt = c ? pc_inc : pc;
         OP_LDC:  lcnt_nxt = arg;
         OP_LOOP: begin
            // Counter stops at zero, so the body runs LDC arg + 1 times.
            if (lcnt != '0) begin
               lcnt_nxt = lcnt - PC_W'(1);
               pc_nxt   = arg;
            end
         end
`ifdef TASK_SEQ_CALL_EN
         OP_CALL: begin
            ret_nxt = pc_inc;
            pc_nxt  = arg;
         end
         OP_RET:  pc_nxt = ret;
`endif
         default: pc_nxt = pc_inc;
      endcase
   end

endmodule

// File: rtl/task_seq_ctrl.sv
// Microcode sequencer for the task bus: one ROM word per cycle, prog_addr is next pc so the sync ROM has it ready.
// No bubbles in RUN; start ignored while busy; done pulses one cycle after END. TASK_SEQ_CALL_EN enables CALL/RET.
module task_seq_ctrl
   import task_seq_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int TASKS_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   task_seq_ctrl_if.slave bus
);
   state_t              state, state_nxt;
   logic [PC_W-1:0]     pc_q, pc_d, pc_nxt;
   logic [PC_W-1:0]     lcnt_q, lcnt_d, lcnt_nxt;
   logic                done_q, done_d;
   logic                is_end;
   logic [TASKS_W-1:0]  word_tasks;
`ifdef TASK_SEQ_CALL_EN
   logic [PC_W-1:0]     ret_q, ret_d, ret_nxt;
`endif

   task_seq_nextpc #(.PC_W(PC_W), .TASKS_W(TASKS_W)) u_nextpc (
      .word       (bus.prog_data),
      .cond       (bus.cond),
      .pc         (pc_q),
      .lcnt       (lcnt_q),
`ifdef TASK_SEQ_CALL_EN
      .ret        (ret_q),
      .ret_nxt    (ret_nxt),
`endif
      .pc_nxt     (pc_nxt),
      .lcnt_nxt   (lcnt_nxt),
      .is_end     (is_end),
      .word_tasks (word_tasks)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         pc_q   <= '0;
         lcnt_q <= '0;
         done_q <= 1'b0;
`ifdef TASK_SEQ_CALL_EN
         ret_q  <= '0;
`endif
      end else begin
         state  <= state_nxt;
         pc_q   <= pc_d;
         lcnt_q <= lcnt_d;
         done_q <= done_d;
`ifdef TASK_SEQ_CALL_EN
         ret_q  <= ret_d;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      pc_d      = pc_q;
      lcnt_d    = lcnt_q;
      done_d    = 1'b0;
`ifdef TASK_SEQ_CALL_EN
      ret_d     = ret_q;
`endif
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_RUN;
               pc_d      = bus.start_addr;
            end
         end
         ST_RUN: begin
            pc_d   = pc_nxt;
            lcnt_d = lcnt_nxt;
`ifdef TASK_SEQ_CALL_EN
            ret_d  = ret_nxt;
`endif
            if (is_end) begin
               state_nxt = ST_IDLE;
               done_d    = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state == ST_RUN);
   assign bus.done      = done_q;
   assign bus.pc        = pc_q;
   assign bus.prog_addr = bus.busy ? pc_nxt : bus.start_addr;
   assign bus.tasks     = bus.busy ? word_tasks : '0;

endmodule

// File: tb/tb_task_seq_ctrl.sv
// Scoreboard bench for task_seq_ctrl: directed programs push expected per-cycle outputs; a negedge monitor checks them.
module tb_task_seq_ctrl;
   import task_seq_pkg::*;

   localparam int PC_W    = 4;
   localparam int TASKS_W = 16;
   localparam int PW      = prog_w(PC_W, TASKS_W);

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [15:0] tasks;
      logic [3:0]  pc;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   obs_t exp_q[$];
   logic [PW-1:0] rom [16];

   task_seq_ctrl_if #(.PC_W(PC_W), .TASKS_W(TASKS_W)) bus ();

   task_seq_ctrl #(.PC_W(PC_W), .TASKS_W(TASKS_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

   // Monitor: every cycle with busy or done consumes one expected observation.
   always @(negedge clk) begin : mon
      obs_t act;
      obs_t e;
      if (!reset && (bus.busy || bus.done)) begin
         act = {bus.busy, bus.done, bus.tasks, bus.pc};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out: unexpected busy=%0b done=%0b tasks=%h pc=%0d, nothing expected",
                     act.busy, act.done, act.tasks, act.pc);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_err++;
               $display("FAIL out: got busy=%0b done=%0b tasks=%h pc=%0d, want busy=%0b done=%0b tasks=%h pc=%0d",
                        act.busy, act.done, act.tasks, act.pc, e.busy, e.done, e.tasks, e.pc);
            end
         end
      end
   end

   function automatic logic [PW-1:0] mk(logic [2:0] op, logic [1:0] cs, logic [3:0] arg, logic [15:0] t);
      return {op, cs, arg, t};
   endfunction

   task automatic ex(logic [3:0] pc, logic [15:0] t);
      exp_q.push_back({1'b1, 1'b0, t, pc});
   endtask

   task automatic exd(logic [3:0] pc);
      exp_q.push_back({1'b0, 1'b1, 16'h0000, pc});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = '0;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic go(logic [3:0] addr);
      bus.start_addr = addr;
      bus.start      = 1'b1;
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic wait_done(string name, int budget);
      int n = 0;
      while (!bus.done && n < budget) begin
         tick();
         n++;
      end
      n_vec++;
      if (!bus.done) begin
         n_err++;
         $display("FAIL %s: done not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic drain(string name);
      tick();
      tick();
      chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.cond       = '0;
      clear_rom();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.done),      32'd0);
      chk("rst_tasks", 32'(bus.tasks),     32'd0);
      chk("rst_pc",    32'(bus.pc),        32'd0);
      chk("rst_paddr", 32'(bus.prog_addr), 32'd0);
      reset = 1'b0;
      tick();

      // Two-word run, then a restart issued in the done cycle.
      clear_rom();
      rom[2] = mk(OP_NEXT, 2'b00, 4'd0, 16'h0001);
      rom[3] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0002);
      ex(2, 16'h0001); ex(3, 16'h0002); exd(3);
      ex(2, 16'h0001); ex(3, 16'h0002); exd(3);
      go(4'd2);
      wait_done("run", 20);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("run_again", 20);
      drain("run");

      // Loop body runs LDC arg + 1 = 4 times.
      clear_rom();
      rom[0] = mk(OP_LDC,  2'b00, 4'd3, 16'h0000);
      rom[1] = mk(OP_NEXT, 2'b00, 4'd0, 16'h0010);
      rom[2] = mk(OP_LOOP, 2'b00, 4'd1, 16'h0020);
      rom[3] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0040);
      ex(0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         ex(1, 16'h0010);
         ex(2, 16'h0020);
      end
      ex(3, 16'h0040); exd(3);
      go(4'd0);
      wait_done("loop", 40);
      drain("loop");

      // WAIT on cond[1], low for 5 executing cycles.
      clear_rom();
      rom[0] = mk(OP_WAIT, 2'b01, 4'd0, 16'h0100);
      rom[1] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0200);
      for (int k = 0; k < 6; k++) ex(0, 16'h0100);
      ex(1, 16'h0200); exd(1);
      bus.cond = 4'b1101;
      go(4'd0);
      repeat (5) tick();
      bus.cond = 4'b0010;
      wait_done("wait", 20);
      bus.cond = '0;
      drain("wait");

      // Branch taken and not taken.
      clear_rom();
      rom[5] = mk(OP_BRC,  2'b00, 4'd9, 16'h0005);
      rom[6] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0006);
      rom[9] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0009);
      ex(5, 16'h0005); ex(9, 16'h0009); exd(9);
      bus.cond = 4'b0001;
      go(4'd5);
      wait_done("brc_taken", 20);
      drain("brc_taken");
      ex(5, 16'h0005); ex(6, 16'h0006); exd(6);
      bus.cond = 4'b1110;
      go(4'd5);
      wait_done("brc_not", 20);
      bus.cond = '0;
      drain("brc_not");

      // pc wraps from 15 to 0.
      clear_rom();
      rom[15] = mk(OP_NEXT, 2'b00, 4'd0, 16'h000F);
      rom[0]  = mk(OP_NEXT, CSEL_END, 4'd0, 16'h000A);
      ex(15, 16'h000F); ex(0, 16'h000A); exd(0);
      go(4'd15);
      wait_done("wrap", 20);
      drain("wrap");

      // CALL/RET, or plain NEXT when the feature is compiled out.
      clear_rom();
      rom[4] = mk(OP_CALL, 2'b00, 4'd8, 16'h0004);
      rom[5] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0050);
      rom[8] = mk(OP_RET,  2'b00, 4'd0, 16'h0008);
      rom[9] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0090);
`ifdef TASK_SEQ_CALL_EN
      ex(4, 16'h0004); ex(8, 16'h0008); ex(5, 16'h0050); exd(5);
`else
      ex(4, 16'h0004); ex(5, 16'h0050); exd(5);
`endif
      go(4'd4);
      wait_done("call", 20);
      drain("call");
`ifdef TASK_SEQ_CALL_EN
      ex(8, 16'h0008); ex(5, 16'h0050); exd(5);
`else
      ex(8, 16'h0008); ex(9, 16'h0090); exd(9);
`endif
      go(4'd8);
      wait_done("ret", 20);
      drain("ret");

      // Reset in the third RUN cycle aborts without a done pulse.
      clear_rom();
      rom[0] = mk(OP_NEXT, 2'b00, 4'd0, 16'h0001);
      rom[1] = mk(OP_NEXT, 2'b00, 4'd0, 16'h0002);
      rom[2] = mk(OP_NEXT, 2'b00, 4'd0, 16'h0003);
      rom[3] = mk(OP_NEXT, CSEL_END, 4'd0, 16'h0004);
      ex(0, 16'h0001); ex(1, 16'h0002);
      go(4'd0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("abort_busy",  32'(bus.busy),  32'd0);
      chk("abort_tasks", 32'(bus.tasks), 32'd0);
      chk("abort_pc",    32'(bus.pc),    32'd0);
      tick();
      reset = 1'b0;
      repeat (4) tick();
      chk("abort_done", 32'(bus.done), 32'd0);
      drain("abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
